// File: rtl/axis_frame_packer.sv
// rtl/axis_frame_packer.sv - buffers window beats and re-emits them as fixed-length, zero-padded frames
module axis_frame_packer #(
    parameter int AXIS_DATA_WIDTH  = 256,
    parameter int FRAME_BEATS      = 100,
    parameter int BEAT_CNT_WIDTH   = 7,
    parameter int FIFO_DEPTH_INDEX = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       win_vld,
    input  logic [AXIS_DATA_WIDTH-1:0] win_data,
    input  logic                       win_end,
    output logic                       win_rdy,
    output logic                       transmit_vld,
    output logic [AXIS_DATA_WIDTH-1:0] transmit_data,
    output logic                       transmit_last,
    input  logic                       transmit_rdy,
    output logic                       read_start_intr,
    output logic [15:0]                frame_cnt
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_INDEX;
    localparam int ENTRY_W = AXIS_DATA_WIDTH + 1;
    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(FRAME_BEATS - 1);

    typedef enum logic {
        STREAM = 1'b0,
        PAD    = 1'b1
    } state_t;

    logic [ENTRY_W-1:0]          mem_q [DEPTH];
    logic [FIFO_DEPTH_INDEX:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_INDEX:0]   rd_ptr_q, rd_ptr_d;
    state_t                      state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;
    logic                        read_start_q, read_start_d;

    logic                        empty;
    logic                        full;
    logic                        push;
    logic                        handshake;
    logic                        at_last_beat;
    logic [ENTRY_W-1:0]          head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_DEPTH_INDEX] != rd_ptr_q[FIFO_DEPTH_INDEX]) &&
                   (wr_ptr_q[FIFO_DEPTH_INDEX-1:0] == rd_ptr_q[FIFO_DEPTH_INDEX-1:0]);
    assign head  = mem_q[rd_ptr_q[FIFO_DEPTH_INDEX-1:0]];

    assign win_rdy         = !full;
    assign push            = win_vld && !full;
    assign at_last_beat    = (beat_cnt_q == LAST_BEAT);
    assign handshake       = transmit_vld && transmit_rdy;
    assign read_start_intr = read_start_q;
    assign frame_cnt       = frame_cnt_q;

    always_comb begin
        transmit_vld  = 1'b0;
        transmit_data = '0;
        transmit_last = 1'b0;
        if (state_q == STREAM) begin
            transmit_vld  = !empty;
            transmit_data = empty ? '0 : head[AXIS_DATA_WIDTH-1:0];
            transmit_last = at_last_beat && !empty;
        end else begin
            transmit_vld  = 1'b1;
            transmit_last = at_last_beat;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        read_start_d = handshake && (beat_cnt_q == '0);
        if (handshake) begin
            if (state_q == STREAM) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // A tag on the final beat of a frame already fills it, so no padding.
            if (at_last_beat) begin
                beat_cnt_d  = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = STREAM;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (state_q == STREAM && head[ENTRY_W-1]) begin
                    state_d = PAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= STREAM;
            beat_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            read_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            read_start_q <= read_start_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_DEPTH_INDEX-1:0]] <= {win_end, win_data};
        end
    end

endmodule

// File: tb/tb_axis_frame_packer.sv
// tb/tb_axis_frame_packer.sv - randomized self-checking bench for axis_frame_packer
module tb_axis_frame_packer;

    localparam int W  = 256;
    localparam int FB = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          win_vld = 1'b0;
    logic [W-1:0]  win_data = '0;
    logic          win_end = 1'b0;
    logic          win_rdy;
    logic          transmit_vld;
    logic [W-1:0]  transmit_data;
    logic          transmit_last;
    logic          transmit_rdy = 1'b0;
    logic          read_start_intr;
    logic [15:0]   frame_cnt;

    axis_frame_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .win_vld         (win_vld),
        .win_data        (win_data),
        .win_end         (win_end),
        .win_rdy         (win_rdy),
        .transmit_vld    (transmit_vld),
        .transmit_data   (transmit_data),
        .transmit_last   (transmit_last),
        .transmit_rdy    (transmit_rdy),
        .read_start_intr (read_start_intr),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        bit           pad;
    } ent_t;

    // Expected output beat stream, derived from accepted input beats.
    ent_t         exp_q[$];
    int           appended;
    int           out_cnt;
    int           occ;
    bit           exp_rs;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;
    int  rdy_mode = 0;
    bit  gap_mode = 1'b0;
    bit  sent_done;
    int  pushes, rs_pulses, last_seen, zero_beats;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_clear();
        exp_q.delete();
        appended   = 0;
        out_cnt    = 0;
        occ        = 0;
        exp_rs     = 1'b0;
        prev_stall = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit   hs;
            bit   pu;
            ent_t e;
            hs = transmit_vld && transmit_rdy;
            pu = win_vld && win_rdy;
            chk("transmit_vld", W'(transmit_vld), W'(exp_q.size() != 0));
            chk("win_rdy", W'(win_rdy), W'(occ < 16));
            chk("read_start_intr", W'(read_start_intr), W'(exp_rs));
            chk("frame_cnt", W'(frame_cnt), W'((out_cnt / FB) % 65536));
            if (prev_stall) begin
                chk("stall_vld", W'(transmit_vld), W'(1));
                chk("stall_data", transmit_data, prev_data);
                chk("stall_last", W'(transmit_last), W'(prev_last));
            end
            if (rst_n && read_start_intr) rs_pulses++;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    fail_now("output_underflow");
                end else begin
                    e = exp_q.pop_front();
                    chk("transmit_data", transmit_data, e.d);
                    chk("transmit_last", W'(transmit_last), W'(out_cnt % FB == FB - 1));
                    if (!e.pad) occ--;
                end
                if (transmit_last) last_seen++;
                if (transmit_data == '0) zero_beats++;
            end
            exp_rs = hs && (out_cnt % FB == 0);
            if (hs) out_cnt++;
            if (pu) begin
                exp_q.push_back('{d: win_data, pad: 1'b0});
                appended++;
                occ++;
                pushes++;
                if (win_end) begin
                    while (appended % FB != 0) begin
                        exp_q.push_back('{d: '0, pad: 1'b1});
                        appended++;
                    end
                end
            end
            prev_stall = transmit_vld && !transmit_rdy;
            prev_data  = transmit_data;
            prev_last  = transmit_last;
            if (!rst_n) model_clear();
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       transmit_rdy = 1'b1;
            1:       transmit_rdy = 1'b0;
            default: transmit_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        pushes     = 0;
        rs_pulses  = 0;
        last_seen  = 0;
        zero_beats = 0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        win_vld = 1'b0;
        win_end = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic send(input logic [W-1:0] d, input logic e);
        int t;
        bit ok;
        if (gap_mode && $urandom_range(0, 3) == 0) begin
            win_vld = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        win_vld  = 1'b1;
        win_data = d;
        win_end  = e;
        t = 0;
        forever begin
            @(negedge clk);
            ok = win_rdy;
            tick();
            t++;
            if (ok) break;
            if (t > 5000) begin
                fail_now("send_timeout");
                break;
            end
        end
        win_vld = 1'b0;
        win_end = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (3) tick();
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        model_clear();
        clear_stats();
        tick();
        chk_en = 1'b1;
        do_reset();

        @(negedge clk);
        chk("reset_vld", W'(transmit_vld), W'(0));
        chk("reset_last", W'(transmit_last), W'(0));
        chk("reset_data", transmit_data, W'(0));
        chk("reset_rs", W'(read_start_intr), W'(0));
        chk("reset_frame_cnt", W'(frame_cnt), W'(0));
        chk("reset_win_rdy", W'(win_rdy), W'(1));
        tick();

        rdy_mode = 0;
        for (int i = 0; i < 100; i++) send(W'(i), 1'b0);
        drain();
        chk("full_frame_cnt", W'(frame_cnt), W'(1));
        chk("full_rs_pulses", W'(rs_pulses), W'(1));
        chk("full_last_count", W'(last_seen), W'(1));

        do_reset();
        for (int i = 0; i < 30; i++) send(W'(i + 1), i == 29);
        drain();
        chk("pad_zero_beats", W'(zero_beats), W'(70));
        chk("pad_frame_cnt", W'(frame_cnt), W'(1));
        chk("pad_last_count", W'(last_seen), W'(1));
        send(W'(16'habc), 1'b0);
        drain();
        chk("pad_next_rs_pulses", W'(rs_pulses), W'(2));
        chk("pad_next_out_cnt", W'(out_cnt), W'(101));

        do_reset();
        rdy_mode  = 1;
        sent_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(W'(i + 500), 1'b0);
                sent_done = 1'b1;
            end
        join_none
        repeat (40) tick();
        @(negedge clk);
        chk("stall_accepted", W'(pushes), W'(16));
        chk("stall_win_rdy", W'(win_rdy), W'(0));
        chk("stall_head_data", transmit_data, W'(500));
        tick();
        rdy_mode = 2;
        begin
            int t;
            t = 0;
            while (!sent_done && t < 5000) begin
                tick();
                t++;
            end
            if (!sent_done) fail_now("stall_sender");
        end
        drain();
        chk("stall_out_cnt", W'(out_cnt), W'(20));

        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 250; i++) send(rnd_data(), 1'b0);
        drain();
        chk("multi_frame_cnt", W'(frame_cnt), W'(2));
        chk("multi_rs_pulses", W'(rs_pulses), W'(3));
        chk("multi_last_count", W'(last_seen), W'(2));
        chk("multi_out_cnt", W'(out_cnt), W'(250));

        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 41; i++) send(W'(i + 1), 1'b0);
        begin
            int t;
            t = 0;
            while (out_cnt != 40 && t < 1000) begin
                tick();
                t++;
            end
            if (out_cnt != 40) fail_now("midreset_wait");
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_vld", W'(transmit_vld), W'(0));
        chk("midreset_frame_cnt", W'(frame_cnt), W'(0));
        chk("midreset_win_rdy", W'(win_rdy), W'(1));
        tick();
        clear_stats();
        for (int i = 0; i < 100; i++) send(W'(i + 7), 1'b0);
        drain();
        chk("midreset_fresh_frame_cnt", W'(frame_cnt), W'(1));
        chk("midreset_fresh_last", W'(last_seen), W'(1));

        do_reset();
        for (int i = 0; i < 110; i++) send(W'(i + 1), i == 99);
        drain();
        chk("tag99_zero_beats", W'(zero_beats), W'(0));
        chk("tag99_out_cnt", W'(out_cnt), W'(110));
        chk("tag99_frame_cnt", W'(frame_cnt), W'(1));
        chk("tag99_rs_pulses", W'(rs_pulses), W'(2));

        do_reset();
        rdy_mode = 2;
        gap_mode = 1'b1;
        for (int i = 0; i < 400; i++) send(rnd_data(), $urandom_range(0, 7) == 0);
        drain();
        gap_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_frame_packer.md
# axis_frame_packer

Frame-assembly stage directly upstream of the AXIS transmitter. It buffers 256-bit window beats from the threshold-cutter datapath in a small FIFO and re-emits them as fixed-length frames of exactly `FRAME_BEATS` beats on the `transmit_*` handshake, with `transmit_last` on the final beat. A window sequence that ends early is zero-padded to full frame length. A one-cycle `read_start_intr` pulse marks each frame start for the read-interrupt generator.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 256: beat width in bits.
- `FRAME_BEATS`, 100: beats per emitted frame; must be ≥2.
- `BEAT_CNT_WIDTH`, 7: width of the beat counter; 2^BEAT_CNT_WIDTH ≥ `FRAME_BEATS`.
- `FIFO_DEPTH_INDEX`, 4: FIFO holds 2^FIFO_DEPTH_INDEX entries of `AXIS_DATA_WIDTH+1` bits (data plus tag).

Ports:
- `clk` in 1: system clock (clk_50M domain).
- `rst_n` in 1: synchronous, active-low reset.
- `win_vld` in 1: upstream beat valid.
- `win_data` in `AXIS_DATA_WIDTH`: upstream beat.
- `win_end` in 1: qualifies the current `win_vld` beat as the last of a window sequence.
- `win_rdy` out 1: FIFO can accept a beat.
- `transmit_vld` out 1: output beat valid.
- `transmit_data` out `AXIS_DATA_WIDTH`: output beat.
- `transmit_last` out 1: final beat of the frame.
- `transmit_rdy` in 1: downstream accepts.
- `read_start_intr` out 1: one-cycle pulse per frame start.
- `frame_cnt` out 16: frames completed; wraps at 0xFFFF→0.

## Operation
- Behaviour on reset:
  - FIFO empty; `win_rdy`=1.
  - `transmit_vld`=0, `transmit_last`=0, `transmit_data`=0.
  - `read_start_intr`=0, `frame_cnt`=0.
  - `beat_cnt`=0; state=STREAM.
- Input side: push `{win_end, win_data}` when `win_vld && win_rdy`. `win_rdy` = !full. A same-cycle pop does not free a slot for that cycle.
- STREAM state:
  - `transmit_vld` = !empty.
  - `transmit_data` = data field of the FIFO head (first-word fall-through).
  - `transmit_last` = (`beat_cnt`==`FRAME_BEATS`-1) && !empty.
  - On handshake (`transmit_vld && transmit_rdy`), pop.
  - If `beat_cnt`==`FRAME_BEATS`-1: `beat_cnt`←0, `frame_cnt`++. A tag on this beat needs no padding.
  - Else if the head tag is 1: `beat_cnt`++, go to PAD.
  - Else: `beat_cnt`++.
- PAD state:
  - `transmit_vld`=1, `transmit_data`=0, FIFO not popped. Input side keeps accepting.
  - `transmit_last` = (`beat_cnt`==`FRAME_BEATS`-1).
  - On handshake at the last beat: `beat_cnt`←0, `frame_cnt`++, go to STREAM.
  - Otherwise each handshake increments `beat_cnt`.
- Untagged beats beyond `FRAME_BEATS` simply start the next frame. Sequences are not split.
- `read_start_intr`: registered. It is 1 in the cycle after any handshake with `beat_cnt`==0, and 0 otherwise.
- Output fields are stable while `transmit_vld && !transmit_rdy`. `transmit_vld` never deasserts without a handshake, except through reset.

## Timing
- Latency: a beat pushed at edge t can be transferred in cycle t+1, if the FIFO was empty and `transmit_rdy`=1.
- Throughput: 1 beat/cycle sustained in both STREAM and PAD.
- STREAM→PAD and PAD→STREAM transitions take effect at the handshake edge, with no bubble cycle.
- Full FIFO with a simultaneous pop: `win_rdy` stays 0 that cycle and rises the next cycle.
- Reset mid-frame: the frame is abandoned with no `transmit_last`. All state returns to reset values at the first edge with `rst_n`=0, and `frame_cnt` is cleared.
- `frame_cnt` updates at the edge of the `transmit_last` handshake.

## Test plan
- Push 100 untagged beats (data = index), `transmit_rdy`=1:
  - 100 beats out in order.
  - `transmit_last` only on beat 99.
  - `read_start_intr` one pulse, the cycle after beat 0.
  - `frame_cnt`=1.
- Push 30 beats with `win_end` on beat 29:
  - Beats 0–29 carry data; beats 30–99 are zero.
  - `last` on beat 99; `frame_cnt`=1.
  - A following input beat begins frame 2 at `beat_cnt` 0.
- Hold `transmit_rdy`=0 while pushing 20 beats:
  - `win_rdy` drops after 16 accepted.
  - Output is stable at beat 0.
  - Release `transmit_rdy`: all 20 emerge in order, with no loss or duplication.
- Push 250 untagged beats with random `transmit_rdy`:
  - Two frames of 100 beats emitted.
  - A partial third frame has 50 beats and no `last`.
  - `frame_cnt`=2; 3 `read_start_intr` pulses.
- Assert `rst_n`=0 at beat 40 of a frame:
  - Next cycle: `transmit_vld`=0, `frame_cnt`=0, `win_rdy`=1.
  - A fresh 100-beat push yields a clean frame.
- Tag `win_end` on beat 99:
  - No PAD state is entered.
  - The next frame starts immediately with the next FIFO beat.
